// File: rtl/wb_omi_initiator.sv
// wb_omi_initiator
//   Wishbone B4 classic single-access master. Accepts one command at a time
//   from a valid/ready stream, runs it on the Wishbone bus, and returns one
//   response per command. An optional ack timeout aborts stalled accesses.
//
//   State table
//     IDLE | waiting for a command, cmd_ready=1
//     BUS  | access in flight, cyc/stb high, timeout timer running
//     RESP | response held on rsp_* until rsp_ready
//
// Parameters
//   TIMEOUT  stb cycles without ack before abort (0 = never abort)
//   CNT_W    width of txn_count
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_we/cmd_adr/cmd_sel/cmd_dat   command fields
//   rsp_valid/rsp_ready              response handshake
//   rsp_dat/rsp_err                  read data (0 for writes, all-ones on timeout), timeout flag
//   wb_cyc/wb_stb/wb_adr/wb_we/wb_sel/wb_dat_o   Wishbone master outputs
//   wb_dat_i/wb_ack                  Wishbone slave returns
//   txn_count                        completed accesses, wraps
//   err_count                        timeouts, saturates at 8'hFF
module wb_omi_initiator #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [3:0]       cmd_sel,
  input  logic [31:0]      cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic [31:0]      wb_adr,
  output logic             wb_we,
  output logic [3:0]       wb_sel,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack,
  output logic [CNT_W-1:0] txn_count,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Down-counter loaded with TIMEOUT-1; the access aborts in the stb cycle
  // where it reads zero, giving exactly TIMEOUT stb cycles.
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic [TO_W-1:0]   tmr_q, tmr_d;
  logic [31:0]       adr_q, adr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       dat_q, dat_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  txn_q, txn_d;
  logic [7:0]        err_q, err_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    txn_d     = txn_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          dat_d   = cmd_dat;
          tmr_d   = TO_LOAD;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack takes priority over a timeout expiring in the same cycle
        if (wb_ack) begin
          rsp_dat_d = we_q ? 32'h0 : wb_dat_i;
          rsp_err_d = 1'b0;
          txn_d     = txn_q + CNT_W'(1);
          state_d   = RESP;
        end else if ((TIMEOUT != 0) && (tmr_q == '0)) begin
          rsp_dat_d = 32'hFFFF_FFFF;
          rsp_err_d = 1'b1;
          txn_d     = txn_q + CNT_W'(1);
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          state_d   = RESP;
        end else begin
          tmr_d = tmr_q - TO_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      txn_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
    end
  end

  // Handshake and bus qualifiers decode straight from the state register so
  // an async reset drops cyc/stb without waiting for a clock.
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign wb_cyc    = (state_q == BUS);
  assign wb_stb    = (state_q == BUS);
  assign wb_adr    = adr_q;
  assign wb_we     = we_q;
  assign wb_sel    = sel_q;
  assign wb_dat_o  = dat_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign txn_count = txn_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_wb_omi_initiator.sv
module tb_wb_omi_initiator;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [31:0]   cmd_adr;
  logic [3:0]    cmd_sel;
  logic [31:0]   cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_dat;
  logic          rsp_err;
  logic          wb_cyc;
  logic          wb_stb;
  logic [31:0]   wb_adr;
  logic          wb_we;
  logic [3:0]    wb_sel;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack;
  logic [CW-1:0] txn_count;
  logic [7:0]    err_count;

  wb_omi_initiator #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack),
    .txn_count(txn_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // reference model state: counters as the spec defines them
  int txn_m;
  int err_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access. Entered and left at a negedge. ack_at = stb cycle
  // (1-based) in which the slave acks; 0 means the slave never acks.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int ack_at, input logic [31:0] rd,
                         input int hold, input bit pend);
    int stb_n;
    bit exp_err;
    int exp_stb;
    logic [31:0] exp_dat;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_sel   = sel;
    cmd_dat   = dat;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_we    = ~we;
    cmd_sel   = ~sel;
    chk("wb_adr", wb_adr, adr);
    chk("wb_we", wb_we, we);
    chk("wb_sel", wb_sel, sel);
    chk("wb_dat_o", wb_dat_o, dat);
    chk("cmd_ready_bus", cmd_ready, 0);
    stb_n = 0;
    for (int i = 1; i <= 40; i++) begin
      if (!wb_cyc) break;
      stb_n++;
      chk("wb_stb_eq_cyc", wb_stb, 1);
      chk("wb_adr_stable", wb_adr, adr);
      wb_ack   = (i == ack_at);
      wb_dat_i = (i == ack_at) ? rd : $urandom;
      @(negedge clk);
    end
    wb_ack = 1'b0;
    exp_err = !(ack_at >= 1 && ack_at <= TO);
    exp_stb = exp_err ? TO : ack_at;
    exp_dat = exp_err ? 32'hFFFF_FFFF : (we ? 32'h0 : rd);
    txn_m = (txn_m + 1) % (1 << CW);
    if (exp_err && err_m < 255) err_m++;
    chk("stb_cycles", stb_n, exp_stb);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_dat", rsp_dat, exp_dat);
    chk("rsp_err", rsp_err, exp_err);
    chk("txn_count", txn_count, txn_m);
    chk("err_count", err_count, err_m);
    rsp_ready = 1'b0;
    cmd_valid = pend;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_dat", rsp_dat, exp_dat);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_bus", wb_cyc, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("pend_not_taken", wb_cyc, 0);
    chk("wb_adr_held", wb_adr, adr);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    txn_m     = 0;
    err_m     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_sel   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    wb_dat_i  = '0;
    wb_ack    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_dat_o", wb_dat_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_txn", txn_count, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // zero-wait write, read with 5 waits, timeout, ack on last allowed cycle
    run_txn(1'b1, 32'h0000_0010, 4'hF, 32'hA5A5_0001, 1, 32'h1234_5678, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0014, 4'hF, 32'h0,         6, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0018, 4'hF, 32'h0,         0, 32'h0,         0, 1'b0);
    run_txn(1'b0, 32'h0000_001C, 4'h3, 32'h0,         8, 32'hCAFE_F00D, 0, 1'b0);
    // response back-pressure with a pending command, and sel=0 passthrough
    run_txn(1'b1, 32'h0000_0020, 4'h0, 32'h5555_AAAA, 2, 32'h0,        10, 1'b1);

    // ack while idle is ignored
    wb_ack   = 1'b1;
    wb_dat_i = $urandom;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("idle_ack_txn", txn_count, txn_m);
    chk("idle_ack_rsp", rsp_valid, 0);
    chk("idle_ack_cyc", wb_cyc, 0);

    // randomized accesses; enough of them to wrap the 4-bit txn_count
    for (int n = 0; n < 22; n++) begin
      run_txn(1'($urandom), $urandom, 4'($urandom), $urandom,
              int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)),
              1'($urandom));
    end

    // reset in the middle of an access
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0000_0040;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_cyc_up", wb_cyc, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cyc_drop", wb_cyc, 0);
    chk("async_stb_drop", wb_stb, 0);
    txn_m = 0;
    err_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_rsp", rsp_valid, 0);
    chk("post_rst_txn", txn_count, 0);
    chk("post_rst_err", err_count, 0);
    wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    chk("spur_ack_txn", txn_count, 0);
    chk("spur_ack_rsp", rsp_valid, 0);
    run_txn(1'b0, 32'h0000_0044, 4'hF, 32'h0, 3, 32'h0BAD_F00D, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
